instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   Instruction fetch unit: the producer of the 32-bit instruction word consumed by the decoder.
//   Holds the fetch PC and issues word reads to instruction memory over a request/response interface.
//   Buffers returned words in an in-order FIFO and presents {instr, instr_pc} downstream with valid/ready.
//   Supports a one-cycle redirect (branch/jump) that flushes buffered and in-flight fetches.
// PARAMETERS
//   RESET_PC    32'h0000_0000  fetch PC after reset; bits [1:0] must be 0
//   FIFO_DEPTH  2              instruction buffer entries; power of 2, >= 2; also the max in-flight + buffered total
// PORTS
//   clk              in   1   clock, all state on rising edge
//   rst              in   1   asynchronous, active-high reset
//   imem_req_valid   out  1   fetch request offered
//   imem_req_ready   in   1   memory accepts request this cycle
//   imem_req_addr    out  32  word-aligned fetch address
//   imem_resp_valid  in   1   read data returned (in request order, cannot be stalled)
//   imem_resp_data   in   32  returned instruction word
//   redirect_valid   in   1   one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc      in   32  new fetch PC; bits [1:0] ignored (forced to 0)
//   instr_valid      out  1   instr/instr_pc hold a valid instruction
//   instr_ready      in   1   downstream consumes instruction this cycle
//   instr            out  32  instruction word to decoder
//   instr_pc         out  32  address instr was fetched from
// BEHAVIOUR
//   - Reset: fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0; imem_req_valid=0,
//     imem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0. First request may issue the cycle after rst falls.
//   - imem_req_addr = fetch_pc always. imem_req_valid = !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH).
//   - Accept = imem_req_valid && imem_req_ready: outstanding++, fetch_pc += 4 (mod 2^32; 0xFFFF_FFFC wraps to 0).
//   - Once asserted, imem_req_valid/addr stay stable until accepted; the only permitted withdrawal is a redirect cycle.
//   - Response: outstanding--. If drop_cnt>0: discard word, drop_cnt--. Else push {data, pc} into FIFO; the
//     pushed pc comes from an internal response-PC register advanced by 4 per kept response.
//   - Credit rule guarantees no FIFO overflow; a push to a full FIFO is an assertion failure.
//   - instr_valid = FIFO non-empty (registered; earliest the cycle after imem_resp_valid; no bypass).
//     instr/instr_pc = FIFO head; pop on instr_valid && instr_ready. Push and pop in the same cycle are both allowed.
//   - instr/instr_pc must hold stable while instr_valid && !instr_ready.
//   - Redirect (redirect_valid=1), effective next cycle:
//     - fetch_pc and resp-PC <= {redirect_pc[31:2],2'b00}; FIFO flushed.
//     - drop_cnt <= outstanding - imem_resp_valid (any response in the redirect cycle is discarded).
//     - No request accepted; no pop; instr_valid forced 0 this cycle.
//   - Back-to-back redirects: the last one wins; drop_cnt recomputed from the current outstanding count.
//   - Reset mid-operation clears everything immediately; responses arriving after reset are the bench's responsibility (must not occur).
//   - Counters outstanding/drop_cnt: $clog2(FIFO_DEPTH+1) bits; they never underflow (assert).
// TESTING
//   - Reset: rst=1 -> all outputs at reset values; release, req_ready=1 -> req addr 0x0 then 0x4 on consecutive cycles.
//   - Stream, 1-cycle memory, instr_ready=1 -> instr 0x00000013 @pc 0x0, 0x4, 0x8 ... one per cycle after fill.
//   - Backpressure: instr_ready=0 -> exactly FIFO_DEPTH requests issued, then req_valid=0; instr held stable.
//   - Redirect to 0x103 with 2 in flight -> both responses dropped, next req addr 0x100, first instr_pc 0x100.
//   - Redirect in the same cycle as resp_valid -> that word never appears; drop_cnt = outstanding-1.
//   - Wrap: redirect to 0xFFFF_FFFC -> instr_pc 0xFFFF_FFFC followed by 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word reads to instruction memory, buffers the
// returned words in order and hands {instr, instr_pc} to the decoder.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   buf_data [FIFO_DEPTH];
    logic [31:0]   buf_pc   [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic          started;
    logic [CW:0]   credit;
    logic [31:0]   redirect_aligned;
    logic          accept;
    logic          keep;
    logic          pop;

    // Credits count both in-flight and buffered words, so a returning
    // response always has a FIFO slot waiting for it.
    assign credit           = {1'b0, outstanding} + {1'b0, fifo_count};
    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req_valid = started && !redirect_valid
                            && (credit < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign keep           = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;

    assign instr_valid = (fifo_count != '0) && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    assign instr       = buf_data[rd_ptr];
    assign instr_pc    = buf_pc[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started     <= 1'b0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else begin
            if (imem_resp_valid)
                assert (outstanding != '0) else $error("instr_fetch: response with nothing outstanding");
            if (keep)
                assert (fifo_count != CW'(FIFO_DEPTH)) else $error("instr_fetch: push to full buffer");

            started <= 1'b1;
            if (redirect_valid) begin
                // Every fetch still in flight belongs to the old path; a
                // response arriving right now is discarded as well.
                fetch_pc    <= redirect_aligned;
                resp_pc     <= redirect_aligned;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                fifo_count  <= '0;
                outstanding <= outstanding - CW'(imem_resp_valid);
                drop_cnt    <= outstanding - CW'(imem_resp_valid);
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 32'd4;
                outstanding <= outstanding + CW'(accept) - CW'(imem_resp_valid);
                if (imem_resp_valid && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CW'(1);
                if (keep) begin
                    buf_data[wr_ptr] <= imem_resp_data;
                    buf_pc[wr_ptr]   <= resp_pc;
                    wr_ptr           <= wr_ptr + PW'(1);
                    resp_pc          <= resp_pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                fifo_count <= fifo_count + CW'(keep) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory model with adjustable latency and a
// scoreboard of expected {pc, word} pairs pushed on request acceptance.
module tb_instr_fetch;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [63:0] exp_q[$];
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    logic [31:0] pop_pc[$];
    logic        hold_v = 1'b0;
    logic [31:0] hold_i, hold_p;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock cycle: sample outputs mid-cycle, then advance the memory model.
    task automatic tick();
        logic acc, pop;
        logic [63:0] e;
        @(negedge clk);
        acc = req_valid && req_ready;
        pop = instr_valid && instr_ready;
        if (redirect_valid) begin
            chk("req_valid_in_redirect", 32'(req_valid), 32'd0);
            chk("instr_valid_in_redirect", 32'(instr_valid), 32'd0);
        end else if (hold_v) begin
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_instr", instr, hold_i);
            chk("hold_pc", instr_pc, hold_p);
        end
        hold_v = instr_valid && !instr_ready && !redirect_valid;
        hold_i = instr;
        hold_p = instr_pc;
        if (pop) begin
            if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("instr_pc", instr_pc, e[63:32]);
                chk("instr", instr, e[31:0]);
            end
            pop_pc.push_back(instr_pc);
        end
        if (acc) begin
            exp_q.push_back({req_addr, memf(req_addr)});
            acc_addr.push_back(req_addr);
            acc_cyc.push_back(cyc);
            q_addr.push_back(req_addr);
            q_due.push_back(cyc + mem_lat);
        end
        if (redirect_valid) exp_q.delete();
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = memf(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            resp_valid = 1'b0;
            resp_data  = 32'h0;
        end
    endtask

    initial begin
        req_ready = 0; resp_valid = 0; resp_data = 0;
        redirect_valid = 0; redirect_pc = 0; instr_ready = 0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_req_addr", req_addr, 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 0; req_ready = 1; instr_ready = 1; mem_lat = 1;

        // Streaming after reset
        repeat (12) tick();
        chk("first_reqs_seen", 32'(acc_addr.size() >= 2), 32'd1);
        if (acc_addr.size() >= 2) begin
            chk("first_req_addr", acc_addr[0], 32'h0);
            chk("second_req_addr", acc_addr[1], 32'h4);
            chk("req_consecutive", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
        end
        chk("stream_pops_seen", 32'(pop_pc.size() >= 3), 32'd1);
        if (pop_pc.size() >= 3) begin
            chk("stream_pc0", pop_pc[0], 32'h0);
            chk("stream_pc1", pop_pc[1], 32'h4);
            chk("stream_pc2", pop_pc[2], 32'h8);
        end
        pop_pc.delete();
        repeat (8) tick();
        chk("stream_rate", 32'(pop_pc.size()), 32'd8);
        if (pop_pc.size() == 8) chk("stream_span", pop_pc[7] - pop_pc[0], 32'd28);

        // Redirect with two fetches in flight
        req_ready = 0;
        repeat (6) tick();
        mem_lat = 5; req_ready = 1;
        tick(); tick();
        req_ready = 0;
        chk("inflight_two", 32'(q_addr.size()), 32'd2);
        redirect_valid = 1; redirect_pc = 32'h0000_0103; req_ready = 1; mem_lat = 2;
        acc_addr.delete(); pop_pc.delete();
        tick();
        repeat (20) tick();
        chk("redir_reqs_seen", 32'(acc_addr.size() > 0 && pop_pc.size() > 0), 32'd1);
        if (acc_addr.size() > 0) chk("redir_req_addr", acc_addr[0], 32'h100);
        if (pop_pc.size() > 0) chk("redir_first_pc", pop_pc[0], 32'h100);

        // Redirect in the same cycle as a response
        req_ready = 0;
        repeat (10) tick();
        mem_lat = 3; req_ready = 1;
        tick(); tick();
        req_ready = 0;
        for (int i = 0; i < 10 && !resp_valid; i++) tick();
        chk("resp_before_redirect", 32'(resp_valid), 32'd1);
        redirect_valid = 1; redirect_pc = 32'h0000_0300; req_ready = 1;
        pop_pc.delete();
        tick();
        repeat (20) tick();
        chk("same_cycle_pops_seen", 32'(pop_pc.size() > 0), 32'd1);
        if (pop_pc.size() > 0) chk("same_cycle_first_pc", pop_pc[0], 32'h300);

        // Backpressure: buffer fills, requests stop, head held stable
        instr_ready = 0; mem_lat = 1;
        redirect_valid = 1; redirect_pc = 32'h0000_0200;
        acc_addr.delete();
        tick();
        repeat (12) tick();
        chk("bp_req_count", 32'(acc_addr.size()), 32'(DEPTH));
        chk("bp_req_valid_low", 32'(req_valid), 32'd0);
        chk("bp_instr_pc", instr_pc, 32'h200);
        instr_ready = 1;
        pop_pc.delete();
        repeat (10) tick();
        chk("bp_drain_seen", 32'(pop_pc.size() > 0), 32'd1);
        if (pop_pc.size() > 0) chk("bp_drain_pc", pop_pc[0], 32'h200);

        // Fetch PC wrap
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        pop_pc.delete();
        tick();
        repeat (10) tick();
        chk("wrap_pops_seen", 32'(pop_pc.size() >= 2), 32'd1);
        if (pop_pc.size() >= 2) begin
            chk("wrap_pc_top", pop_pc[0], 32'hFFFF_FFFC);
            chk("wrap_pc_zero", pop_pc[1], 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
